// File: rtl/audio_spi_tdm_transceiver.sv
// SPI sample receiver feeding a FIFO that is replayed as an I2S or TDM stream.
// Shares one divided bit clock between the SPI side and the DAC side.
module audio_spi_tdm_transceiver #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int MCLK_DIV   = 2,
  parameter int MODE       = 0,
  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          input_clk,
  input  logic          reset,
  input  logic          spi_mosi,
  input  logic          spi_cs,
  output logic          serial_clk,
  output logic          i2s_dac_mclk,
  output logic          i2s_ws,
  output logic          i2s_sd,
  output logic          RED_LED,
  output logic          GREEN_LED,
  output logic          BLUE_LED,
  output logic [BW-1:0] i2s_bit_counter,
  output logic [CW-1:0] i2s_ch_counter
);

  localparam int DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int MW  = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int SCW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_t;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          rise_tick;
  logic          fall_tick;
  logic [MW-1:0] mdiv_cnt;
  logic [MW-1:0] mdiv_nxt;

  assign rise_tick = (div_cnt == DW'(CLK_DIV/2 - 1));
  assign fall_tick = (div_cnt == DW'(CLK_DIV - 1));
  assign div_nxt   = fall_tick ? '0 : div_cnt + DW'(1);
  assign mdiv_nxt  = (mdiv_cnt == MW'(MCLK_DIV - 1)) ?
                     '0 : mdiv_cnt + MW'(1);

  // Bit clock divider; serial_clk is high in the upper half of the count.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      serial_clk <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      serial_clk <= (div_nxt >= DW'(CLK_DIV/2));
    end
  end

  // Independent DAC master clock divider.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      mdiv_cnt     <= '0;
      i2s_dac_mclk <= 1'b0;
    end else begin
      mdiv_cnt     <= mdiv_nxt;
      i2s_dac_mclk <= (mdiv_nxt >= MW'(MCLK_DIV/2));
    end
  end

  logic [SCW-1:0]      rx_cnt;
  logic [SAMPLE_W-1:0] rx_sh;
  logic [SAMPLE_W-1:0] rx_nxt;
  logic                rx_done;

  assign rx_nxt  = SAMPLE_W'({rx_sh, spi_mosi});
  assign rx_done = rise_tick && !spi_cs &&
                   (rx_cnt == SCW'(SAMPLE_W - 1));

  // SPI shift-in; deselect throws away any partial word.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      rx_cnt <= '0;
      rx_sh  <= '0;
    end else if (spi_cs) begin
      rx_cnt <= '0;
      rx_sh  <= '0;
    end else if (rise_tick) begin
      rx_sh  <= rx_nxt;
      rx_cnt <= rx_done ? '0 : rx_cnt + SCW'(1);
    end
  end

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [LW-1:0]       level;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                load;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = rx_done && !full;
  assign pop   = load && !empty;

  // Sample storage; no reset needed since level gates every read.
  always_ff @(posedge input_clk) begin
    if (push) mem[wptr] <= rx_nxt;
  end

  // FIFO pointers, fill level and sticky overflow flag.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      RED_LED <= 1'b0;
    end else begin
      if (push)
        wptr <= (wptr == AW'(FIFO_DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (pop)
        rptr <= (rptr == AW'(FIFO_DEPTH - 1)) ? '0 : rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (rx_done && full) RED_LED <= 1'b1;
    end
  end

  tx_state_t state_q;
  tx_state_t state_d;

  // Transmitter state register.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Start once a full frame is buffered; never stop until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (level >= LW'(NUM_CH)) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign GREEN_LED = (state_q == RUN);

  logic              started;
  logic [BW-1:0]     bit_q;
  logic [CW-1:0]     ch_q;
  logic [BW-1:0]     bit_n;
  logic [CW-1:0]     ch_n;
  logic              ws_q;
  logic              ws_n;
  logic [SLOT_W-1:0] shreg;
  logic [SLOT_W-1:0] load_val;
  logic              last_bit;
  logic              last_ch;

  assign last_bit = (bit_q == BW'(SLOT_W - 1));
  assign last_ch  = (ch_q == CW'(NUM_CH - 1));
  assign load     = fall_tick && GREEN_LED && (!started || last_bit);
  assign load_val = empty ? '0 :
                    (SLOT_W'(mem[rptr]) << (SLOT_W - SAMPLE_W));

  // Next slot position and word-select level for the coming bit.
  always_comb begin
    bit_n = '0;
    ch_n  = '0;
    ws_n  = ws_q;
    if (started) begin
      if (last_bit) begin
        bit_n = '0;
        ch_n  = last_ch ? '0 : ch_q + CW'(1);
      end else begin
        bit_n = bit_q + BW'(1);
        ch_n  = ch_q;
      end
    end
    if (MODE == 0) begin
      if (started && bit_n == BW'(SLOT_W - 1))
        ws_n = (ch_n != CW'(NUM_CH - 1)) && !ch_n[0];
    end else begin
      ws_n = started && (bit_n == BW'(SLOT_W - 1)) &&
             (ch_n == CW'(NUM_CH - 1));
    end
  end

  // Slot counters, output shifter and sticky underflow flag.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      started  <= 1'b0;
      bit_q    <= '0;
      ch_q     <= '0;
      ws_q     <= 1'b0;
      shreg    <= '0;
      BLUE_LED <= 1'b0;
    end else if (GREEN_LED && fall_tick) begin
      started <= 1'b1;
      bit_q   <= bit_n;
      ch_q    <= ch_n;
      ws_q    <= ws_n;
      shreg   <= load ? load_val : shreg << 1;
      if (load && empty) BLUE_LED <= 1'b1;
    end
  end

  assign i2s_sd          = shreg[SLOT_W-1];
  assign i2s_ws          = ws_q;
  assign i2s_bit_counter = bit_q;
  assign i2s_ch_counter  = ch_q;

endmodule
